field_serdes_tagged: RTL and testbench

//  - Parametrised, sequential successor to the 8-bit split/combine block.
//  - Accepts one WORD_W-bit word per valid/ready handshake and splits it into NUM_FIELDS fields of FIELD_W bits.
//  - Streams the fields out one per handshake, least-significant field first.
//  - Reassembles the fields, field 0 in the MSBs, into a tagged word with TAG_VAL as its LSB.
//  - Sits between a word-wide producer and a narrow (FIELD_W) downstream datapath.

---
 rtl/field_serdes_tagged.sv | 90 +++++++++
 tb/tb_field_serdes_tagged.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_serdes_tagged.sv
// Splits a WORD_W-bit word into NUM_FIELDS fields streamed LSB-field first, then
// publishes the fields re-packed field-0-first with TAG_VAL appended as the LSB.
module field_serdes_tagged #(
    parameter int   FIELD_W    = 2,
    parameter int   NUM_FIELDS = 4,
    parameter logic TAG_VAL    = 1'b1,
    localparam int  WORD_W     = FIELD_W * NUM_FIELDS,
    localparam int  IDX_W      = $clog2(NUM_FIELDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FIELD_W-1:0] out_field,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic [WORD_W:0]   number,
    output logic              number_valid
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    state_t                     state;
    logic [WORD_W-1:0]          shift_reg;
    logic [WORD_W-FIELD_W-1:0]  acc;
    logic [IDX_W-1:0]           idx;
    logic [WORD_W-1:0]          shift_next;
    logic [WORD_W-1:0]          acc_next;

    // The shift register drains to zero by the end of a word, so out_field reads 0 in IDLE.
    assign out_field  = shift_reg[FIELD_W-1:0];
    assign out_idx    = idx;
    assign shift_next = shift_reg >> FIELD_W;
    assign acc_next   = {acc, shift_reg[FIELD_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            acc          <= '0;
            idx          <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            number       <= '0;
            number_valid <= 1'b0;
        end else begin
            number_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shift_reg <= in_data;
                        acc       <= '0;
                        idx       <= '0;
                        out_last  <= (LAST_IDX == '0);
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        shift_reg <= shift_next;
                        acc       <= acc_next[WORD_W-FIELD_W-1:0];
                        if (out_last) begin
                            // Final field: publish and reopen the input in the same cycle.
                            number       <= {acc_next, TAG_VAL};
                            number_valid <= 1'b1;
                            idx          <= '0;
                            out_last     <= 1'b0;
                            out_valid    <= 1'b0;
                            in_ready     <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            idx      <= idx + 1'b1;
                            out_last <= ((idx + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_field_serdes_tagged.sv
// Bench for field_serdes_tagged: directed scenarios plus randomized words checked
// against an arithmetic model of the field split and tagged re-assembly.
module tb_field_serdes_tagged;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, number_valid;
    logic [7:0] in_data;
    logic [1:0] out_field, out_idx;
    logic [8:0] number;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_last, w_number_valid;
    logic [11:0] w_in_data;
    logic [3:0]  w_out_field;
    logic [1:0]  w_out_idx;
    logic [12:0] w_number;

    int errors = 0;
    int checks = 0;

    field_serdes_tagged dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field),
        .out_idx(out_idx), .out_last(out_last),
        .number(number), .number_valid(number_valid)
    );

    field_serdes_tagged #(.FIELD_W(4), .NUM_FIELDS(3)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_field(w_out_field),
        .out_idx(w_out_idx), .out_last(w_out_last),
        .number(w_number), .number_valid(w_number_valid)
    );

    // Field i of a word is simply bits [i*fw +: fw].
    function automatic int ref_field(int w, int fw, int i);
        return (w >> (i * fw)) & ((1 << fw) - 1);
    endfunction

    // Fields concatenated with field 0 most significant, then the tag bit.
    function automatic int ref_number(int w, int fw, int nf);
        int n = 0;
        for (int i = 0; i < nf; i++) n = (n << fw) | ref_field(w, fw, i);
        return (n << 1) | 1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_field, out_idx, out_last, number_valid} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctl: got rdy=%b vld=%b fld=%h idx=%h last=%b nv=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, out_field, out_idx, out_last, number_valid);
        end
        checks++;
        if (number !== 9'h000) begin errors++; $display("FAIL reset_number: got %h want 000", number); end
        checks++;
        if ({w_in_ready, w_out_valid, w_number} !== {1'b1, 1'b0, 13'h0}) begin
            errors++;
            $display("FAIL reset_wide: got rdy=%b vld=%b num=%h want 1 0 0000", w_in_ready, w_out_valid, w_number);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_data = 8'hE4; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: in_ready got %b want 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_field !== 2'(ref_field(32'hE4, 2, i)) || out_idx !== 2'(i)
                || out_last !== (i == 3) || number_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_field%0d: got vld=%b fld=%h idx=%h last=%b nv=%b want 1 %h %h %b 0", i,
                         out_valid, out_field, out_idx, out_last, number_valid,
                         2'(ref_field(32'hE4, 2, i)), 2'(i), (i == 3));
            end
            @(negedge clk);
        end
        checks++;
        if (number_valid !== 1'b1 || number !== 9'h037 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_number: got nv=%b num=%h rdy=%b vld=%b want 1 037 1 0",
                     number_valid, number, in_ready, out_valid);
        end
        @(negedge clk);
        checks++;
        if (number_valid !== 1'b0 || number !== 9'h037) begin
            errors++;
            $display("FAIL basic_hold: got nv=%b num=%h want 0 037", number_valid, number);
        end
    endtask

    task automatic test_stall();
        int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int hs = 0;
        int hs_dut = 0;
        in_valid = 1'b1; in_data = 8'hE4; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_field !== 2'(ref_field(32'hE4, 2, hs)) || out_idx !== 2'(hs)
                || out_last !== (hs == 3)) begin
                errors++;
                $display("FAIL stall_cycle%0d: got vld=%b fld=%h idx=%h last=%b want 1 %h %h %b", k,
                         out_valid, out_field, out_idx, out_last, 2'(ref_field(32'hE4, 2, hs)), 2'(hs), (hs == 3));
            end
            if (out_valid && pat[k] != 0) hs_dut++;
            out_ready = pat[k][0];
            @(negedge clk);
            if (pat[k] != 0) hs++;
        end
        out_ready = 1'b1;
        checks++;
        if (hs_dut != 4 || number_valid !== 1'b1 || number !== 9'h037 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_number: got hs=%0d nv=%b num=%h vld=%b want 4 1 037 0",
                     hs_dut, number_valid, number, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        @(negedge clk);
        in_data = 8'h1B;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_field !== 2'(ref_field(32'hFF, 2, i)) || out_idx !== 2'(i)) begin
                errors++;
                $display("FAIL b2b_first%0d: got vld=%b fld=%h idx=%h want 1 %h %h", i,
                         out_valid, out_field, out_idx, 2'(ref_field(32'hFF, 2, i)), 2'(i));
            end
            @(negedge clk);
        end
        checks++;
        if (number_valid !== 1'b1 || number !== 9'(ref_number(32'hFF, 2, 4)) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_number1: got nv=%b num=%h rdy=%b want 1 1ff 1", number_valid, number, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_field !== 2'(ref_field(32'h1B, 2, i)) || out_idx !== 2'(i)) begin
                errors++;
                $display("FAIL b2b_second%0d: got vld=%b fld=%h idx=%h want 1 %h %h", i,
                         out_valid, out_field, out_idx, 2'(ref_field(32'h1B, 2, i)), 2'(i));
            end
            @(negedge clk);
        end
        checks++;
        if (number_valid !== 1'b1 || number !== 9'h1C9) begin
            errors++;
            $display("FAIL b2b_number2: got nv=%b num=%h want 1 1c9", number_valid, number);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midword();
        in_valid = 1'b1; in_data = 8'hE4; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_idx !== 2'd2) begin errors++; $display("FAIL midrst_pre: idx got %h want 2", out_idx); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_field, out_idx, out_last, number_valid} !== 8'b1000_0000
            || number !== 9'h000) begin
            errors++;
            $display("FAIL midrst_async: got rdy=%b vld=%b fld=%h idx=%h last=%b nv=%b num=%h want 1 0 0 0 0 0 000",
                     in_ready, out_valid, out_field, out_idx, out_last, number_valid, number);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (number_valid !== 1'b0 || out_valid !== 1'b0 || number !== 9'h000) begin
                errors++;
                $display("FAIL midrst_quiet%0d: got nv=%b vld=%b num=%h want 0 0 000", k,
                         number_valid, out_valid, number);
            end
        end
        in_valid = 1'b1; in_data = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (number_valid !== 1'b1 || number !== 9'h001) begin
            errors++;
            $display("FAIL midrst_next: got nv=%b num=%h want 1 001", number_valid, number);
        end
        @(negedge clk);
    endtask

    task automatic test_wide();
        w_in_valid = 1'b1; w_in_data = 12'hABC; w_out_ready = 1'b1;
        @(negedge clk);
        w_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (w_out_valid !== 1'b1 || w_out_field !== 4'(ref_field(32'hABC, 4, i)) || w_out_idx !== 2'(i)
                || w_out_last !== (i == 2)) begin
                errors++;
                $display("FAIL wide_field%0d: got vld=%b fld=%h idx=%h last=%b want 1 %h %h %b", i,
                         w_out_valid, w_out_field, w_out_idx, w_out_last,
                         4'(ref_field(32'hABC, 4, i)), 2'(i), (i == 2));
            end
            @(negedge clk);
        end
        checks++;
        if (w_number_valid !== 1'b1 || w_number !== 13'h1975 || w_number !== 13'(ref_number(32'hABC, 4, 3))) begin
            errors++;
            $display("FAIL wide_number: got nv=%b num=%h want 1 1975", w_number_valid, w_number);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        in_valid = 1'b1; in_data = 8'h4E; out_ready = 1'b1;
        @(negedge clk);
        in_data = 8'hB1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_field !== 2'(ref_field(32'h4E, 2, 0)) || out_idx !== 2'd0) begin
                errors++;
                $display("FAIL busy_hold%0d: got rdy=%b fld=%h idx=%h want 0 %h 0", k,
                         in_ready, out_field, out_idx, 2'(ref_field(32'h4E, 2, 0)));
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_field !== 2'(ref_field(32'h4E, 2, i)) || out_idx !== 2'(i)) begin
                errors++;
                $display("FAIL busy_field%0d: got vld=%b fld=%h idx=%h want 1 %h %h", i,
                         out_valid, out_field, out_idx, 2'(ref_field(32'h4E, 2, i)), 2'(i));
            end
            @(negedge clk);
        end
        checks++;
        if (number_valid !== 1'b1 || number !== 9'(ref_number(32'h4E, 2, 4))) begin
            errors++;
            $display("FAIL busy_number: got nv=%b num=%h want 1 %h", number_valid, number,
                     9'(ref_number(32'h4E, 2, 4)));
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_idle: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int w = int'($urandom_range(0, 255));
            int hs = 0;
            bit done = 0;
            in_valid = 1'b0; out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid = 1'b1; in_data = 8'(w);
            @(negedge clk);
            for (int c = 0; c < 80 && !done; c++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data = 8'($urandom_range(0, 255));
                if (number_valid === 1'b1) begin
                    in_valid = 1'b0;
                    done = 1;
                    checks++;
                    if (hs != 4 || number !== 9'(ref_number(w, 2, 4))) begin
                        errors++;
                        $display("FAIL rand%0d_number: got num=%h hs=%0d want %h 4", n, number, hs,
                                 9'(ref_number(w, 2, 4)));
                    end
                end else begin
                    checks++;
                    if (hs > 3 || out_valid !== 1'b1 || in_ready !== 1'b0 || out_field !== 2'(ref_field(w, 2, hs))
                        || out_idx !== 2'(hs) || out_last !== (hs == 3)) begin
                        errors++;
                        $display("FAIL rand%0d_field: got vld=%b rdy=%b fld=%h idx=%h last=%b want 1 0 %h %h %b",
                                 n, out_valid, in_ready, out_field, out_idx, out_last,
                                 2'(ref_field(w, 2, hs)), 2'(hs), (hs == 3));
                    end
                    out_ready = ($urandom_range(0, 9) < 7);
                    if (out_ready) hs++;
                    @(negedge clk);
                end
            end
            if (!done) begin
                errors++;
                $display("FAIL rand%0d_timeout: got no number_valid want pulse", n);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_midword();
        test_wide();
        test_busy_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
